// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-RAM loader.
//   ADDR_W / DATA_W : RAM word-address and word widths (2Kx32 RAM)
//   CNT_W           : width of a word count that can express 0..IMEM_DEPTH
//   MEM_EN/MEM_DIS  : levels for the active-low RAM controls CEN/WEN/OEN
//   state_t         : loader FSM states
package imem_pkg;

  localparam int ADDR_W     = 11;
  localparam int DATA_W     = 32;
  localparam int IMEM_DEPTH = 2048;
  localparam int CNT_W      = ADDR_W + 1;

  // Largest legal word_count, sized to the count port.
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(IMEM_DEPTH);

  localparam logic MEM_EN  = 1'b0;
  localparam logic MEM_DIS = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_VERIFY,
    S_WAIT_Q,
    S_CHECK,
    S_FINISH
  } state_t;

endpackage

// File: rtl/imem_readback.sv
// Readback engine for the loader's verify phase.
// Steps a read address from base_i through base_i+count_i-1 (wrapping at
// the RAM depth), one address per cycle, and accumulates the words the RAM
// returns RD_LAT cycles after it samples each address.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start_i     : arms the engine; clears the address counter and rsum
//   base_i      : first read address
//   count_i     : number of words to read back (>= 1 when started)
//   mem_q_i     : RAM read data
//   issue_o     : a read address is offered this cycle (addr_o)
//   last_o      : the offered address is the final one
//   addr_o      : read address to be registered onto the RAM port
//   drained_o   : all issued reads have been accumulated
//   rsum_o      : sum of read words mod 2^DATA_W
module imem_readback
  import imem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic [DATA_W-1:0] mem_q_i,
  output logic              issue_o,
  output logic              last_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              drained_o,
  output logic [DATA_W-1:0] rsum_o
);

  logic              active_q;
  logic [CNT_W-1:0]  cnt_q;
  // vld_p_q[0] is aligned with the registered RAM address; bit RD_LAT marks
  // the cycle in which the matching mem_q is valid.
  logic [RD_LAT:0]   vld_p_q;
  logic [DATA_W-1:0] rsum_q;

  assign issue_o   = active_q;
  assign last_o    = active_q && (cnt_q == (count_i - CNT_W'(1)));
  assign addr_o    = base_i + cnt_q[ADDR_W-1:0];
  assign drained_o = !active_q && (vld_p_q == '0);
  assign rsum_o    = rsum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      vld_p_q  <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      vld_p_q  <= '0;
    end else begin
      vld_p_q <= {vld_p_q[RD_LAT-1:0], active_q};
      if (active_q) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (last_o) active_q <= 1'b0;
      end
    end
  end

  // Accumulator is pure data: cleared when armed, so it needs no reset.
  always_ff @(posedge clk) begin
    if (start_i) begin
      rsum_q <= '0;
    end else if (vld_p_q[RD_LAT]) begin
      rsum_q <= rsum_q + mem_q_i;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-RAM loader: accepts program words over valid/ready, writes
// them to the 2Kx32 RAM (active-low CEN/WEN/OEN, synchronous read), reads
// the block back, compares checksums and holds the CPU until verified.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : one-cycle pulse, begins a load when idle
//   base_addr           : first RAM word address (sampled on start)
//   word_count          : words to load, 0..2048 (sampled on start)
//   in_valid/in_data    : host word stream
//   in_ready            : loader accepts in_data this cycle
//   mem_cen/wen/oen     : RAM controls, active low
//   mem_addr/mem_d      : RAM address and write data
//   mem_q               : RAM read data
//   busy                : load or verify in progress
//   done                : one-cycle pulse on successful verify
//   error               : sticky verify mismatch / bad count
//   checksum            : sum of written words, valid when not busy
//   cpu_hold            : CPU stall until a verified load
module imem_loader
  import imem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic              mem_oen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum,
  output logic              cpu_hold
);

  state_t            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  idx_q;
  logic [DATA_W-1:0] wsum_q;

  logic              in_ready_q;
  logic              cen_q;
  logic              wen_q;
  logic              oen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] d_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic [DATA_W-1:0] checksum_q;
  logic              hold_q;

  logic              hs;
  logic              last_wr;
  logic              rb_start;
  logic              rb_issue;
  logic              rb_last;
  logic              rb_drained;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] rb_rsum;
  logic [ADDR_W-1:0] wr_addr_d;

  assign hs        = (state_q == S_WRITE) && in_valid && in_ready_q;
  assign last_wr   = (idx_q == (count_q - CNT_W'(1)));
  // Arm the readback on the final handshake so its first address is ready
  // in the first VERIFY cycle.
  assign rb_start  = hs && last_wr;
  // Address arithmetic is ADDR_W wide, so base+idx wraps at the RAM depth.
  assign wr_addr_d = base_q + idx_q[ADDR_W-1:0];

  imem_readback #(
    .RD_LAT (RD_LAT)
  ) u_readback (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (rb_start),
    .base_i    (base_q),
    .count_i   (count_q),
    .mem_q_i   (mem_q),
    .issue_o   (rb_issue),
    .last_o    (rb_last),
    .addr_o    (rb_addr),
    .drained_o (rb_drained),
    .rsum_o    (rb_rsum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      wsum_q     <= '0;
      in_ready_q <= 1'b0;
      cen_q      <= MEM_DIS;
      wen_q      <= MEM_DIS;
      oen_q      <= MEM_DIS;
      addr_q     <= '0;
      d_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      checksum_q <= '0;
      hold_q     <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b0;
          cen_q      <= MEM_DIS;
          wen_q      <= MEM_DIS;
          oen_q      <= MEM_DIS;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
          if (start) begin
            base_q  <= base_addr;
            count_q <= word_count;
            error_q <= 1'b0;
            if (word_count == '0) begin
              checksum_q <= '0;
              done_q     <= 1'b1;
              hold_q     <= 1'b0;
              state_q    <= S_FINISH;
            end else if (word_count > DEPTH_CNT) begin
              error_q <= 1'b1;
              hold_q  <= 1'b1;
            end else begin
              busy_q     <= 1'b1;
              hold_q     <= 1'b1;
              wsum_q     <= '0;
              idx_q      <= '0;
              in_ready_q <= 1'b1;
              state_q    <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          if (hs) begin
            cen_q  <= MEM_EN;
            wen_q  <= MEM_EN;
            addr_q <= wr_addr_d;
            d_q    <= in_data;
            wsum_q <= wsum_q + in_data;
            idx_q  <= idx_q + CNT_W'(1);
            if (last_wr) begin
              in_ready_q <= 1'b0;
              state_q    <= S_VERIFY;
            end
          end else begin
            cen_q <= MEM_DIS;
            wen_q <= MEM_DIS;
          end
        end

        S_VERIFY: begin
          wen_q <= MEM_DIS;
          if (rb_issue) begin
            cen_q  <= MEM_EN;
            oen_q  <= MEM_EN;
            addr_q <= rb_addr;
          end else begin
            cen_q <= MEM_DIS;
          end
          if (rb_last) state_q <= S_WAIT_Q;
        end

        // No new reads; OEN stays enabled until the last word is captured.
        S_WAIT_Q: begin
          cen_q <= MEM_DIS;
          if (rb_drained) state_q <= S_CHECK;
        end

        S_CHECK: begin
          oen_q      <= MEM_DIS;
          busy_q     <= 1'b0;
          checksum_q <= wsum_q;
          if (rb_rsum == wsum_q) begin
            done_q  <= 1'b1;
            hold_q  <= 1'b0;
            state_q <= S_FINISH;
          end else begin
            error_q <= 1'b1;
            hold_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end

        S_FINISH: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign mem_cen  = cen_q;
  assign mem_wen  = wen_q;
  assign mem_oen  = oen_q;
  assign mem_addr = addr_q;
  assign mem_d    = d_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign checksum = checksum_q;
  assign cpu_hold = hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: behavioural 2Kx32 RAM, write/read monitors and
// a reference model that derives expected addresses, data and checksum
// directly from the load parameters.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [10:0] base_addr = '0;
  logic [11:0] word_count = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        mem_cen;
  logic        mem_wen;
  logic        mem_oen;
  logic [10:0] mem_addr;
  logic [31:0] mem_d;
  logic [31:0] mem_q;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] checksum;
  logic        cpu_hold;

  int checks = 0;
  int errors = 0;

  imem_loader #(.RD_LAT(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_cen    (mem_cen),
    .mem_wen    (mem_wen),
    .mem_oen    (mem_oen),
    .mem_addr   (mem_addr),
    .mem_d      (mem_d),
    .mem_q      (mem_q),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .checksum   (checksum),
    .cpu_hold   (cpu_hold)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: synchronous write, one-cycle synchronous read.
  logic [31:0] ram [0:2047];
  logic [31:0] q_r = '0;
  logic        corrupt_en = 1'b0;
  logic [10:0] corrupt_addr = '0;

  always @(posedge clk) begin
    if (!mem_cen && !mem_wen) ram[mem_addr] <= mem_d;
    else if (!mem_cen) q_r <= (corrupt_en && mem_addr == corrupt_addr) ? 32'hDEADBEEF : ram[mem_addr];
  end
  assign mem_q = mem_oen ? 32'h0 : q_r;

  // Monitors log every RAM write/read cycle and count done cycles.
  logic [10:0] wlog_a[$];
  logic [31:0] wlog_d[$];
  logic [10:0] rlog_a[$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (rst_n && !mem_cen && !mem_wen) begin
      wlog_a.push_back(mem_addr);
      wlog_d.push_back(mem_d);
    end
    if (rst_n && !mem_cen && mem_wen) rlog_a.push_back(mem_addr);
    if (done) done_cnt <= done_cnt + 1;
  end

  logic [31:0] stim_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic reset_checks(input string pfx);
    check({pfx, ".in_ready"}, 32'(in_ready), 32'd0);
    check({pfx, ".mem_cen"},  32'(mem_cen),  32'd1);
    check({pfx, ".mem_wen"},  32'(mem_wen),  32'd1);
    check({pfx, ".mem_oen"},  32'(mem_oen),  32'd1);
    check({pfx, ".mem_addr"}, 32'(mem_addr), 32'd0);
    check({pfx, ".mem_d"},    mem_d,         32'd0);
    check({pfx, ".busy"},     32'(busy),     32'd0);
    check({pfx, ".done"},     32'(done),     32'd0);
    check({pfx, ".error"},    32'(error),    32'd0);
    check({pfx, ".checksum"}, checksum,      32'd0);
    check({pfx, ".cpu_hold"}, 32'(cpu_hold), 32'd1);
  endtask

  task automatic fill_random(input int n);
    stim_q.delete();
    for (int k = 0; k < n; k++) stim_q.push_back($urandom);
  endtask

  // Zero-length load: done pulses for exactly one cycle, CPU released.
  task automatic zero_load();
    int d0;
    d0 = done_cnt;
    base_addr = 11'($urandom_range(2047));
    word_count = 12'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("zero.done", 32'(done), 32'd1);
    check("zero.cpu_hold", 32'(cpu_hold), 32'd0);
    check("zero.checksum", checksum, 32'd0);
    check("zero.error", 32'(error), 32'd0);
    step();
    check("zero.done_drop", 32'(done), 32'd0);
    step();
    check("zero.done_cnt", 32'(done_cnt - d0), 32'd1);
  endtask

  // One load of stim_q[0..n-1] at base b; the model is plain arithmetic on
  // the word list: addresses (b+k) mod 2048, checksum = sum mod 2^32.
  task automatic run_load(input logic [10:0] b, input int n, input int gap_pct,
                          input bit toggle, input bit corrupt, input bit expect_ok);
    int          w0, r0, d0, i, cyc, ea;
    bit          seen;
    logic [31:0] exp_sum;
    exp_sum = '0;
    for (int k = 0; k < n; k++) exp_sum = exp_sum + stim_q[k];
    w0 = wlog_a.size();
    r0 = rlog_a.size();
    d0 = done_cnt;
    corrupt_en = corrupt;
    corrupt_addr = b + 11'd1;
    base_addr = b;
    word_count = 12'(n);
    start = 1'b1;
    step();
    start = 1'b0;
    check("load.busy", 32'(busy), 32'd1);
    check("load.cpu_hold", 32'(cpu_hold), 32'd1);
    i = 0;
    cyc = 0;
    while (i < n && cyc < 20000) begin
      if (toggle) in_valid = (cyc % 2 == 0);
      else if (gap_pct > 0) in_valid = (int'($urandom_range(99)) >= gap_pct);
      else in_valid = 1'b1;
      in_data = in_valid ? stim_q[i] : $urandom;
      if (in_valid && in_ready) i++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    in_data = $urandom;
    check("feed.words", 32'(i), 32'(n));
    check("feed.ready_drop", 32'(in_ready), 32'd0);
    if (gap_pct == 0 && !toggle) check("feed.cycles", 32'(cyc), 32'(n));
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 5000) begin
      if (expect_ok ? done : (error && !busy)) seen = 1'b1;
      else begin
        step();
        cyc++;
      end
    end
    check("end.seen", 32'(seen), 32'd1);
    check("end.busy", 32'(busy), 32'd0);
    check("end.checksum", checksum, exp_sum);
    check("end.error", 32'(error), expect_ok ? 32'd0 : 32'd1);
    check("end.cpu_hold", 32'(cpu_hold), expect_ok ? 32'd0 : 32'd1);
    step();
    check("end.done_after", 32'(done), 32'd0);
    step();
    step();
    check("end.done_cnt", 32'(done_cnt - d0), expect_ok ? 32'd1 : 32'd0);
    check("wr.count", 32'(wlog_a.size() - w0), 32'(n));
    check("rd.count", 32'(rlog_a.size() - r0), 32'(n));
    for (int k = 0; k < n; k++) begin
      ea = (int'(b) + k) % 2048;
      if (wlog_a.size() > w0 + k) begin
        check("wr.addr", 32'(wlog_a[w0 + k]), 32'(ea));
        check("wr.data", wlog_d[w0 + k], stim_q[k]);
      end
      if (rlog_a.size() > r0 + k) check("rd.addr", 32'(rlog_a[r0 + k]), 32'(ea));
      check("ram.word", ram[ea], stim_q[k]);
    end
    corrupt_en = 1'b0;
  endtask

  initial begin
    int w0;
    // Reset and idle state.
    #1 rst_n = 1'b0;
    #3 reset_checks("rst");
    step();
    step();
    rst_n = 1'b1;
    step();
    reset_checks("idle");

    zero_load();

    // base 0, words 1..4 back-to-back.
    stim_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_load(11'd0, 4, 0, 1'b0, 1'b0, 1'b1);
    check("b2b.checksum10", checksum, 32'd10);

    // Same load with in_valid toggling.
    stim_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_load(11'd0, 4, 0, 1'b1, 1'b0, 1'b1);
    check("tog.checksum10", checksum, 32'd10);

    // Wrap at top of RAM.
    stim_q = '{32'hA, 32'hB, 32'hC, 32'hD};
    run_load(11'd2046, 4, 0, 1'b0, 1'b0, 1'b1);
    fill_random(16);
    run_load(11'd2040, 16, 20, 1'b0, 1'b0, 1'b1);

    // Random loads with random host gaps.
    for (int t = 0; t < 3; t++) begin
      fill_random(int'($urandom_range(40, 1)));
      run_load(11'($urandom_range(2047)), stim_q.size(), 30, 1'b0, 1'b0, 1'b1);
    end

    // Full-depth load.
    fill_random(2048);
    run_load(11'($urandom_range(2047)), 2048, 0, 1'b0, 1'b0, 1'b1);

    // Readback fault on the 2nd word, then a new start clears error.
    fill_random(4);
    run_load(11'd100, 4, 0, 1'b0, 1'b1, 1'b0);
    step();
    check("fault.hold_idle", 32'(cpu_hold), 32'd1);
    zero_load();

    // Oversized count: error, no writes.
    w0 = wlog_a.size();
    base_addr = 11'd5;
    word_count = 12'd2049;
    start = 1'b1;
    step();
    start = 1'b0;
    check("big.error", 32'(error), 32'd1);
    check("big.cpu_hold", 32'(cpu_hold), 32'd1);
    check("big.busy", 32'(busy), 32'd0);
    check("big.in_ready", 32'(in_ready), 32'd0);
    step();
    step();
    check("big.no_write", 32'(wlog_a.size() - w0), 32'd0);
    fill_random(3);
    run_load(11'd7, 3, 0, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of WRITE.
    fill_random(8);
    base_addr = 11'd500;
    word_count = 12'd8;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data = stim_q[k];
      step();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 reset_checks("midrst");
    w0 = wlog_a.size();
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    check("midrst.no_write", 32'(wlog_a.size() - w0), 32'd0);
    check("midrst.cpu_hold", 32'(cpu_hold), 32'd1);
    check("midrst.busy", 32'(busy), 32'd0);
    zero_load();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Write-side counterpart of the instruction fetch path. Accepts a stream of 32-bit program words over a valid/ready handshake and writes them into the 2Kx32 instruction RAM, which has active-low CEN/WEN/OEN and a synchronous read. After writing, it reads the block back, compares checksums, and holds the CPU in stall until the load is verified. It sits between the boot/debug host interface and the instruction RAM port, ahead of the fetch mux.

Parameters:
ADDR_W, 11, RAM word-address width (2048 words)
DATA_W, 32, RAM word width
RD_LAT, 1, RAM read latency in cycles (Q valid RD_LAT cycles after A is sampled)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a load when idle
base_addr  in  11  first RAM word address, sampled on start
word_count  in  12  number of words to load (0..2048), sampled on start
in_valid  in  1  host word available
in_data  in  32  host program word
in_ready  out  1  loader accepts in_data this cycle
mem_cen  out  1  RAM chip enable, active low
mem_wen  out  1  RAM write enable, active low
mem_oen  out  1  RAM output enable, active low
mem_addr  out  11  RAM address
mem_d  out  32  RAM write data
mem_q  in  32  RAM read data
busy  out  1  load or verify in progress
done  out  1  one-cycle pulse on successful verify
error  out  1  sticky until next accepted start; verify mismatch or bad count
checksum  out  32  sum of written words mod 2^32, valid when not busy
cpu_hold  out  1  high from start until done; also high while error is set

Behaviour:
- Reset values: in_ready=0, mem_cen=1, mem_wen=1, mem_oen=1, mem_addr=0, mem_d=0, busy=0, done=0, error=0, checksum=0, cpu_hold=1. The CPU stays held until the first successful load.
- All outputs are registered. The FSM has states IDLE, WRITE, VERIFY, WAIT_Q, CHECK, FINISH.
- IDLE: start=1 samples base_addr and word_count and clears error.
  - word_count=0 goes to FINISH directly: done pulses, checksum=0.
  - word_count>2048 sets error, keeps cpu_hold=1, and returns to IDLE.
  - Otherwise go to WRITE: busy=1, cpu_hold=1, and wsum, rsum and the counter are cleared.
  - start while busy is ignored.
- WRITE: in_ready=1. On a handshake (in_valid&in_ready) the next edge drives:
  - mem_cen=0, mem_wen=0, mem_addr=base+idx (mod 2048, wraps), mem_d=in_data;
  - wsum+=in_data and idx+=1.
  - Cycles without a handshake drive mem_cen=1, mem_wen=1 (no write).
  - Throughput is one word per cycle.
  - After the handshake for word idx=count-1, in_ready drops on the next edge and the FSM enters VERIFY.
- VERIFY: drives mem_cen=0, mem_wen=1, mem_oen=0, with mem_addr stepping base..base+count-1 (mod 2048), one address per cycle. Reads are pipelined. mem_q is captured RD_LAT cycles after each address edge, and rsum+=mem_q.
- WAIT_Q: drains the last RD_LAT reads, then goes to CHECK.
- CHECK: checksum<=wsum.
  - rsum==wsum: go to FINISH. done pulses for 1 cycle, busy=0, cpu_hold=0.
  - Mismatch: error=1, busy=0, cpu_hold stays 1, return to IDLE.
- FINISH returns to IDLE after one cycle. In IDLE the memory is deselected (cen=wen=oen=1).
- Wrap: base=2040, count=16 writes addresses 2040..2047 then 0..7.
- Reset mid-operation: returns to IDLE immediately with reset values. A partially written RAM is not reported. cpu_hold=1.
- in_data is ignored when in_valid=0. in_valid with in_ready=0 leaves the data unconsumed; the host must hold it.

Decomposition:
- Shared package `imem_pkg`:
  - ADDR_W/DATA_W constants;
  - the state enum;
  - IMEM_DEPTH=2048;
  - active-low control encodings (MEM_EN=0, MEM_DIS=1).
- One sub-module is natural: `imem_readback`, the pipelined address stepper plus rsum accumulator for VERIFY/WAIT_Q, parameterised by RD_LAT.
- The top level holds the FSM, the write path and the handshake.

Test Plan:
- Reset then idle: cpu_hold=1, mem_cen=1, mem_wen=1, in_ready=0; start with count=0 -> done pulse 1 cycle later, cpu_hold=0, checksum=0.
- base=0, count=4, words 1,2,3,4 back-to-back with in_valid=1:
  - RAM[0..3]=1..4;
  - 4 write cycles with mem_wen=0;
  - checksum=10, done, cpu_hold=0.
- Same load with in_valid toggling 1,0,1,0:
  - no writes in gap cycles;
  - identical RAM contents and checksum=10.
- base=2046, count=4, data A,B,C,D:
  - writes to addresses 2046, 2047, 0, 1;
  - verify reads the same order;
  - done.
- Verify fault: bench forces mem_q to 0xDEADBEEF on the 2nd readback -> error=1, done never pulses, cpu_hold=1. The next start clears error.
- count=2049 -> error=1, no RAM write. Separately, assert rst_n=0 mid-WRITE -> all outputs at reset values asynchronously, FSM in IDLE.
